// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: synchronises rx, validates the start
// bit at mid-bit, shifts data LSB-first and checks the stop bit.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [4:0] START_MID = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);
  localparam int         ALIGN     = 8 - DBIT;

  state_t     state, state_next;
  logic [4:0] s_cnt, s_cnt_next;
  logic [2:0] n_cnt, n_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] dout_next;
  logic       done_next, ferr_next;
  logic       rx_meta, rx_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shift_reg <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_next;
      s_cnt     <= s_cnt_next;
      n_cnt     <= n_cnt_next;
      shift_reg <= shift_next;
      dout      <= dout_next;
      rx_done   <= done_next;
      frame_err <= ferr_next;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    shift_next = shift_reg;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == START_MID) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
            // A line that is high again at mid-bit was only a glitch.
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            shift_next = {rx_s, shift_reg[7:1]};
            if (n_cnt == DATA_LAST) state_next = STOP;
            else                    n_cnt_next = n_cnt + 3'd1;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            s_cnt_next = '0;
            dout_next  = shift_reg >> ALIGN;
            if (rx_s) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = WAIT_HIGH;
              ferr_next  = 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low break line reports one error, not a stream of frames.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: default 8N1 instance plus a 7-bit,
// 2-stop-bit instance, frames compared against an expected-byte queue model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] dout8, dout7;
  logic       rx_done8, rx_done7, frame_err8, frame_err7;

  int n_cmp = 0;
  int n_err = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  logic [7:0] got_done8[$], got_ferr8[$], got_done7[$], got_ferr7[$];

  uart_rx dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx8),
    .dout(dout8), .rx_done(rx_done8), .frame_err(frame_err8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done(rx_done7), .frame_err(frame_err7)
  );

  always #5 clk = ~clk;

  // Tick generator: s_tick changes on the falling edge, one tick every tick_div clks.
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  // Event monitor: records every strobe with the byte presented alongside it.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done8 || frame_err8) begin
        n_cmp++;
        if (rx_done8 && frame_err8) begin
          n_err++;
          $display("FAIL excl8: rx_done=%b frame_err=%b, required not both high", rx_done8, frame_err8);
        end
      end
      if (rx_done7 || frame_err7) begin
        n_cmp++;
        if (rx_done7 && frame_err7) begin
          n_err++;
          $display("FAIL excl7: rx_done=%b frame_err=%b, required not both high", rx_done7, frame_err7);
        end
      end
      if (rx_done8)   got_done8.push_back(dout8);
      if (frame_err8) got_ferr8.push_back(dout8);
      if (rx_done7)   got_done7.push_back(dout7);
      if (frame_err7) got_ferr7.push_back(dout7);
    end
  end

  task automatic clear_events();
    got_done8.delete(); got_ferr8.delete();
    got_done7.delete(); got_ferr7.delete();
  endtask

  // Hold the chosen line at b for n s_tick periods.
  task automatic drive_bit(input int sel, input logic b, input int n);
    @(negedge clk);
    if (sel == 7) rx7 = b;
    else          rx8 = b;
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                            input int stop_ticks, input logic stop_val);
    drive_bit(sel, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], 16);
    drive_bit(sel, stop_val, stop_ticks);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dout8, rx_done8, frame_err8} !== 10'h0) begin
      n_err++;
      $display("FAIL reset8: dout=%h done=%b ferr=%b, required all 0", dout8, rx_done8, frame_err8);
    end
    n_cmp++;
    if ({dout7, rx_done7, frame_err7} !== 10'h0) begin
      n_err++;
      $display("FAIL reset7: dout=%h done=%b ferr=%b, required all 0", dout7, rx_done7, frame_err7);
    end
    reset = 1'b0;
    clear_events();
    drive_bit(8, 1'b1, 5);
  endtask

  task automatic test_single_a5();
    clear_events();
    send_frame(8, 8'hA5, 8, 16, 1'b1);
    drive_bit(8, 1'b1, 20);
    n_cmp++;
    if (got_done8.size() !== 1) begin
      n_err++;
      $display("FAIL a5_count: rx_done pulses=%0d, required 1", got_done8.size());
    end else begin
      n_cmp++;
      if (got_done8[0] !== 8'hA5) begin
        n_err++;
        $display("FAIL a5_data: dout=%h, required a5", got_done8[0]);
      end
    end
    n_cmp++;
    if (got_ferr8.size() !== 0) begin
      n_err++;
      $display("FAIL a5_ferr: frame_err pulses=%0d, required 0", got_ferr8.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h55};
    clear_events();
    foreach (exp_q[i]) send_frame(8, exp_q[i], 8, 16, 1'b1);
    drive_bit(8, 1'b1, 20);
    n_cmp++;
    if (got_done8.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: rx_done pulses=%0d, required %0d", got_done8.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_done8[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: dout=%h, required %h", i, got_done8[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (got_ferr8.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_ferr: frame_err pulses=%0d, required 0", got_ferr8.size());
    end
  endtask

  task automatic test_glitch();
    clear_events();
    drive_bit(8, 1'b0, 4);
    drive_bit(8, 1'b1, 30);
    n_cmp++;
    if (got_done8.size() + got_ferr8.size() !== 0) begin
      n_err++;
      $display("FAIL glitch_events: done=%0d ferr=%0d, required 0/0", got_done8.size(), got_ferr8.size());
    end
    n_cmp++;
    if (dout8 !== 8'h55) begin
      n_err++;
      $display("FAIL glitch_dout: dout=%h, required 55 (unchanged)", dout8);
    end
  endtask

  task automatic test_frame_err();
    clear_events();
    send_frame(8, 8'h3C, 8, 116, 1'b0);
    drive_bit(8, 1'b1, 20);
    n_cmp++;
    if (got_ferr8.size() !== 1) begin
      n_err++;
      $display("FAIL ferr_count: frame_err pulses=%0d, required 1", got_ferr8.size());
    end else begin
      n_cmp++;
      if (got_ferr8[0] !== 8'h3C) begin
        n_err++;
        $display("FAIL ferr_data: dout=%h, required 3c", got_ferr8[0]);
      end
    end
    n_cmp++;
    if (got_done8.size() !== 0) begin
      n_err++;
      $display("FAIL ferr_done: rx_done pulses=%0d, required 0", got_done8.size());
    end
    send_frame(8, 8'h81, 8, 16, 1'b1);
    drive_bit(8, 1'b1, 20);
    n_cmp++;
    if (got_done8.size() !== 1 || dout8 !== 8'h81) begin
      n_err++;
      $display("FAIL ferr_recover: done=%0d dout=%h, required 1 pulse with 81", got_done8.size(), dout8);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] data;
    data = 8'hF0;
    clear_events();
    drive_bit(8, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(8, data[i], 16);
    drive_bit(8, data[4], 8);
    @(negedge clk);
    reset = 1'b1;
    rx8   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dout8, rx_done8, frame_err8} !== 10'h0) begin
      n_err++;
      $display("FAIL midreset_out: dout=%h done=%b ferr=%b, required all 0", dout8, rx_done8, frame_err8);
    end
    reset = 1'b0;
    drive_bit(8, 1'b1, 20);
    send_frame(8, 8'h12, 8, 16, 1'b1);
    drive_bit(8, 1'b1, 20);
    n_cmp++;
    if (got_done8.size() !== 1 || got_ferr8.size() !== 0 || dout8 !== 8'h12) begin
      n_err++;
      $display("FAIL midreset_next: done=%0d ferr=%0d dout=%h, required 1/0 with 12",
               got_done8.size(), got_ferr8.size(), dout8);
    end
  endtask

  task automatic test_dbit7();
    logic [7:0] data;
    data = 8'h5A;
    clear_events();
    drive_bit(7, 1'b0, 16);
    for (int i = 0; i < 7; i++) drive_bit(7, data[i], 16);
    drive_bit(7, 1'b1, 20);
    n_cmp++;
    if (got_done7.size() !== 0) begin
      n_err++;
      $display("FAIL dbit7_early: rx_done pulses=%0d before stop end, required 0", got_done7.size());
    end
    drive_bit(7, 1'b1, 12);
    drive_bit(7, 1'b1, 20);
    n_cmp++;
    if (got_done7.size() !== 1 || dout7 !== 8'h5A) begin
      n_err++;
      $display("FAIL dbit7_data: done=%0d dout=%h, required 1 pulse with 5a", got_done7.size(), dout7);
    end
    n_cmp++;
    if (got_ferr7.size() + got_done8.size() + got_ferr8.size() !== 0) begin
      n_err++;
      $display("FAIL dbit7_other: ferr7=%0d done8=%0d ferr8=%0d, required 0",
               got_ferr7.size(), got_done8.size(), got_ferr8.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_done[$], exp_ferr[$];
    logic [7:0] data;
    logic       ok;
    int         gap;
    clear_events();
    for (int f = 0; f < 16; f++) begin
      tick_div = int'($urandom_range(1, 3));
      data     = 8'($urandom);
      ok       = ($urandom_range(0, 4) != 0);
      if (ok) begin
        send_frame(8, data, 8, 16, 1'b1);
        exp_done.push_back(data);
        gap = int'($urandom_range(0, 3));
      end else begin
        send_frame(8, data, 8, 16 + int'($urandom_range(0, 20)), 1'b0);
        exp_ferr.push_back(data);
        gap = int'($urandom_range(2, 5));
      end
      if (gap > 0) drive_bit(8, 1'b1, gap);
    end
    drive_bit(8, 1'b1, 25);
    tick_div = 1;
    n_cmp++;
    if (got_done8.size() !== exp_done.size() || got_ferr8.size() !== exp_ferr.size()) begin
      n_err++;
      $display("FAIL rand_count: done=%0d ferr=%0d, required %0d/%0d",
               got_done8.size(), got_ferr8.size(), exp_done.size(), exp_ferr.size());
    end else begin
      foreach (exp_done[i]) begin
        n_cmp++;
        if (got_done8[i] !== exp_done[i]) begin
          n_err++;
          $display("FAIL rand_done[%0d]: dout=%h, required %h", i, got_done8[i], exp_done[i]);
        end
      end
      foreach (exp_ferr[i]) begin
        n_cmp++;
        if (got_ferr8[i] !== exp_ferr[i]) begin
          n_err++;
          $display("FAIL rand_ferr[%0d]: dout=%h, required %h", i, got_ferr8[i], exp_ferr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_dbit7();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
